// File: rtl/caliptra_prim_ram_1p_arb_pkg.sv
// caliptra_prim_ram_1p_arb_pkg
//   Shared types for the two-requester single-port RAM arbiter.
//   - req_id_e    : identifies which requester owns an in-flight read
//   - arb_state_e : zero-fill sequencer state (used only when
//                   CALIPTRA_PRIM_RAM_1P_ARB_INIT_EN is defined)
package caliptra_prim_ram_1p_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef enum logic {
    ARB_INIT  = 1'b0,
    ARB_READY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/caliptra_prim_rr_arb2.sv
// caliptra_prim_rr_arb2
//   Two-way round-robin arbiter with a combinational same-cycle grant.
//   Ports:
//     clk_i, rst_i : clock, synchronous active-high reset
//     req[1:0]     : requests (bit 0 = A, bit 1 = B)
//     gnt[1:0]     : one-hot grant, valid only while en is high
//     en           : allows grants to be issued
//   The pointer remembers the last requester served and moves only on a
//   grant; it resets to "B served last" so A wins the first tie.
module caliptra_prim_rr_arb2
  import caliptra_prim_ram_1p_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic       en
);

  req_id_e r_last;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[0] && (!req[1] || r_last == REQ_B)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= REQ_B;
    end else if (gnt[0]) begin
      r_last <= REQ_A;
    end else if (gnt[1]) begin
      r_last <= REQ_B;
    end
  end

endmodule

// File: rtl/caliptra_prim_ram_1p_arb.sv
// caliptra_prim_ram_1p_arb
//   Front end that shares one synchronous single-port SRAM (1-cycle read
//   latency, bit write mask) between a host port A and an engine port B.
//   Ports:
//     clk_i, rst_i           : clock, synchronous active-high reset
//     {a,b}_req/write/addr/wdata/wmask_i : requester inputs
//     {a,b}_gnt_o            : request accepted this cycle (combinational)
//     {a,b}_rvalid_o/rdata_o : read return, one cycle after a read grant
//     ram_*_o / ram_rdata_i  : RAM macro interface
//     init_done_o            : arbiter accepting requests
//   Optional feature (macro CALIPTRA_PRIM_RAM_1P_ARB_INIT_EN): zero-fill the
//   whole RAM after reset before any request is granted.
module caliptra_prim_ram_1p_arb
  import caliptra_prim_ram_1p_arb_pkg::*;
#(
  parameter  int Width = 32,
  parameter  int Depth = 128,
  localparam int Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_req_i,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic             a_gnt_o,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  input  logic             b_req_i,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic             b_gnt_o,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i,
  output logic             init_done_o
);

  logic          w_init_done;
  logic          w_init_wr;
  logic [Aw-1:0] w_init_addr;
  logic [1:0]    w_gnt;
  logic          w_read_gnt;
  logic          r_rvalid;
  req_id_e       r_rvalid_id;

`ifdef CALIPTRA_PRIM_RAM_1P_ARB_INIT_EN
  arb_state_e    r_state;
  arb_state_e    w_state_next;
  logic [Aw-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ARB_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ARB_INIT && r_cnt == Aw'(Depth - 1)) begin
      w_state_next = ARB_READY;
    end
  end

  // Counter holds at the last address once the fill completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_state == ARB_INIT && r_cnt != Aw'(Depth - 1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Qualified with rst_i so nothing reaches the RAM while reset is held.
  always_comb begin
    w_init_wr   = (r_state == ARB_INIT) && !rst_i;
    w_init_done = (r_state == ARB_READY) && !rst_i;
    w_init_addr = r_cnt;
  end
`else
  // No fill needed: ready in every cycle that reset is low.
  assign w_init_wr   = 1'b0;
  assign w_init_done = !rst_i;
  assign w_init_addr = '0;
`endif

  assign init_done_o = w_init_done;

  caliptra_prim_rr_arb2 u_rr_arb2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   ({b_req_i, a_req_i}),
    .gnt   (w_gnt),
    .en    (w_init_done)
  );

  assign a_gnt_o = w_gnt[0];
  assign b_gnt_o = w_gnt[1];

  always_comb begin
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    if (w_init_wr) begin
      ram_req_o   = 1'b1;
      ram_write_o = 1'b1;
      ram_addr_o  = w_init_addr;
      ram_wmask_o = '1;
    end else if (w_gnt[0]) begin
      ram_req_o   = 1'b1;
      ram_write_o = a_write_i;
      ram_addr_o  = a_addr_i;
      ram_wdata_o = a_wdata_i;
      ram_wmask_o = a_wmask_i;
    end else if (w_gnt[1]) begin
      ram_req_o   = 1'b1;
      ram_write_o = b_write_i;
      ram_addr_o  = b_addr_i;
      ram_wdata_o = b_wdata_i;
      ram_wmask_o = b_wmask_i;
    end
  end

  assign w_read_gnt = (w_gnt[0] && !a_write_i) || (w_gnt[1] && !b_write_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid    <= 1'b0;
      r_rvalid_id <= REQ_A;
    end else begin
      r_rvalid    <= w_read_gnt;
      r_rvalid_id <= w_gnt[1] ? REQ_B : REQ_A;
    end
  end

  assign a_rvalid_o = r_rvalid && (r_rvalid_id == REQ_A) && !rst_i;
  assign b_rvalid_o = r_rvalid && (r_rvalid_id == REQ_B) && !rst_i;
  assign a_rdata_o  = a_rvalid_o ? ram_rdata_i : '0;
  assign b_rdata_o  = b_rvalid_o ? ram_rdata_i : '0;

endmodule
